nvdla_partition_rstclk_ctrl: RTL and testbench

- Parametrised partition-level reset and clock-control block; successor to the fixed reset-syncer-plus-override-syncer arrangement in each partition top.
- Synchronises partition reset and clock-override inputs with configurable depth.
- Releases NUM_UNITS sub-unit resets in a staggered sequence to limit di/dt.
- Generates per-unit SLCG clock enables with an idle hold-off counter.
- Sits between the partition top ports and the sub-units of that partition (cmac, cacc, ...).

---
 rtl/nvdla_rstclk_pkg.sv | 15 +
 rtl/nvdla_sync_chain.sv | 26 ++
 rtl/nvdla_partition_rstclk_ctrl.sv | 165 ++++++++++++++++
 tb/tb_nvdla_partition_rstclk_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nvdla_rstclk_pkg.sv
// Shared definitions for the partition reset/clock-control block: sequencer
// state encoding and default timing constants.
package nvdla_rstclk_pkg;

  typedef enum logic [1:0] {
    StRst = 2'd0,
    StRel = 2'd1,
    StRun = 2'd2
  } seq_state_e;

  localparam int unsigned DefaultSyncDepth = 3;
  localparam int unsigned DefaultStagger   = 4;
  localparam int unsigned DefaultIdleHold  = 16;

endpackage

// File: rtl/nvdla_sync_chain.sv
// Multi-flop synchroniser with configurable depth and reset value. Used both
// for reset deassertion (d tied high) and for asynchronous level inputs.
module nvdla_sync_chain #(
  parameter int unsigned Depth  = 3,
  parameter logic        RstVal = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [Depth-1:0] stage;

  // Shift the input through the chain; the last stage is the synchronised value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage <= {Depth{RstVal}};
    end else begin
      stage <= {stage[Depth-2:0], d};
    end
  end

  assign q = stage[Depth-1];

endmodule

// File: rtl/nvdla_partition_rstclk_ctrl.sv
// Partition-level reset and clock control: synchronises the partition reset
// and clock-override requests, releases sub-unit resets one after another to
// spread the inrush current, and produces per-unit SLCG clock enables that
// only gate a unit after it has stayed idle for a hold-off period.
module nvdla_partition_rstclk_ctrl
  import nvdla_rstclk_pkg::*;
#(
  parameter int unsigned NUM_UNITS  = 4,
  parameter int unsigned SYNC_DEPTH = DefaultSyncDepth,
  parameter int unsigned STAGGER    = DefaultStagger,
  parameter int unsigned IDLE_HOLD  = DefaultIdleHold,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                 nvdla_core_clk,
  input  logic                 dla_reset_rstn,
  input  logic                 direct_reset_,
  input  logic                 test_mode,
  input  logic                 nvdla_clk_ovr_on,
  input  logic                 global_clk_ovr_on,
  input  logic                 tmc2slcg_disable_clock_gating,
  input  logic [NUM_UNITS-1:0] unit_idle,
  output logic [NUM_UNITS-1:0] unit_rstn,
  output logic [NUM_UNITS-1:0] unit_clk_en,
  output logic                 dla_clk_ovr_on_sync,
  output logic                 global_clk_ovr_on_sync,
  output logic                 rst_done
);

  localparam int unsigned     IdxW    = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam longint unsigned CntMax  = (64'd1 << CNT_W) - 64'd1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_UNITS - 1);
  localparam logic [CNT_W-1:0] StaggerCnt = CNT_W'(STAGGER);
  localparam logic [CNT_W-1:0] HoldCnt    = CNT_W'(IDLE_HOLD);

  // Illegal parameter combinations stop elaboration.
  if (NUM_UNITS < 1) begin : g_bad_units
    $error("NUM_UNITS must be at least 1");
  end
  if (SYNC_DEPTH < 2 || SYNC_DEPTH > 4) begin : g_bad_depth
    $error("SYNC_DEPTH must be in 2..4");
  end
  if (STAGGER < 1 || STAGGER > 255 || longint'(STAGGER) > CntMax) begin : g_bad_stagger
    $error("STAGGER must be in 1..255 and fit in CNT_W bits");
  end
  if (IDLE_HOLD < 1 || IDLE_HOLD > 255 || longint'(IDLE_HOLD) > CntMax) begin : g_bad_hold
    $error("IDLE_HOLD must be in 1..255 and fit in CNT_W bits");
  end

  logic raw_rstn;
  logic rst_sync_q;
  logic synced_rstn;
  logic dla_ovr_q;
  logic glb_ovr_q;

  assign raw_rstn = dla_reset_rstn & direct_reset_;

  nvdla_sync_chain #(
    .Depth  (SYNC_DEPTH),
    .RstVal (1'b0)
  ) u_rst_sync (
    .clk   (nvdla_core_clk),
    .rst_n (raw_rstn),
    .d     (1'b1),
    .q     (rst_sync_q)
  );

  nvdla_sync_chain #(
    .Depth  (SYNC_DEPTH),
    .RstVal (1'b0)
  ) u_dla_ovr_sync (
    .clk   (nvdla_core_clk),
    .rst_n (raw_rstn),
    .d     (nvdla_clk_ovr_on),
    .q     (dla_ovr_q)
  );

  nvdla_sync_chain #(
    .Depth  (SYNC_DEPTH),
    .RstVal (1'b0)
  ) u_glb_ovr_sync (
    .clk   (nvdla_core_clk),
    .rst_n (raw_rstn),
    .d     (global_clk_ovr_on),
    .q     (glb_ovr_q)
  );

  // Scan bypasses every synchroniser.
  assign synced_rstn            = test_mode ? raw_rstn          : rst_sync_q;
  assign dla_clk_ovr_on_sync    = test_mode ? nvdla_clk_ovr_on  : dla_ovr_q;
  assign global_clk_ovr_on_sync = test_mode ? global_clk_ovr_on : glb_ovr_q;

  seq_state_e             state;
  logic [CNT_W-1:0]       cnt;
  logic [IdxW-1:0]        idx;
  logic [NUM_UNITS-1:0]   unit_rstn_q;
  logic                   rst_done_q;

  // Release sequencer. cnt resets to STAGGER and counts down once per cycle
  // with synced_rstn high, so it holds STAGGER-1 after the first such edge;
  // the edge on which it reaches zero releases the next unit and reloads it.
  // Unit i therefore leaves reset STAGGER*(i+1) edges after synced_rstn rises.
  always_ff @(posedge nvdla_core_clk or negedge raw_rstn) begin
    if (!raw_rstn) begin
      state       <= StRst;
      cnt         <= StaggerCnt;
      idx         <= '0;
      unit_rstn_q <= '0;
      rst_done_q  <= 1'b0;
    end else begin
      unique case (state)
        StRst, StRel: begin
          if (synced_rstn) begin
            if (cnt == CNT_W'(1)) begin
              unit_rstn_q[idx] <= 1'b1;
              cnt              <= StaggerCnt;
              if (idx == LastIdx) begin
                state      <= StRun;
                rst_done_q <= 1'b1;
              end else begin
                state <= StRel;
                idx   <= idx + IdxW'(1);
              end
            end else begin
              cnt   <= cnt - CNT_W'(1);
              state <= StRel;
            end
          end
        end
        StRun: begin
          unit_rstn_q <= '1;
          rst_done_q  <= 1'b1;
        end
        default: state <= StRst;
      endcase
    end
  end

  assign unit_rstn = test_mode ? {NUM_UNITS{raw_rstn}} : unit_rstn_q;
  assign rst_done  = test_mode ? raw_rstn : rst_done_q;

  // Clocks are kept running whenever an override is active or the partition
  // is not yet fully out of reset.
  logic gate_force;
  assign gate_force = dla_clk_ovr_on_sync | global_clk_ovr_on_sync |
                      tmc2slcg_disable_clock_gating | (state != StRun);

  for (genvar i = 0; i < NUM_UNITS; i++) begin : g_slcg
    logic [CNT_W-1:0] hc;

    // Idle hold-off; reloaded while busy or forced so gating always needs a
    // fresh full idle period once the forcing condition goes away.
    always_ff @(posedge nvdla_core_clk or negedge raw_rstn) begin
      if (!raw_rstn) begin
        hc <= HoldCnt;
      end else if (!unit_idle[i] || gate_force) begin
        hc <= HoldCnt;
      end else if (hc != '0) begin
        hc <= hc - CNT_W'(1);
      end
    end

    assign unit_clk_en[i] = test_mode | gate_force | ~unit_idle[i] | (hc != '0);
  end

endmodule

// File: tb/tb_nvdla_partition_rstclk_ctrl.sv
// Directed bench for nvdla_partition_rstclk_ctrl. Stimulus pushes expected
// output values tagged with the clock count at which they must hold; a
// monitor samples the outputs on every falling edge and retires due entries.
module tb_nvdla_partition_rstclk_ctrl;

  localparam logic [15:0] MRstn = 16'h000F;
  localparam logic [15:0] MEn   = 16'h00F0;
  localparam logic [15:0] MDone = 16'h0100;
  localparam logic [15:0] MDovr = 16'h0200;
  localparam logic [15:0] MGovr = 16'h0400;

  typedef struct {
    int          when;
    logic [15:0] mask;
    logic [15:0] val;
    string       name;
  } exp_t;

  logic       clk = 1'b0;
  logic       dla_reset_rstn = 1'b0;
  logic       direct_reset_ = 1'b1;
  logic       test_mode = 1'b0;
  logic       nvdla_clk_ovr_on = 1'b0;
  logic       global_clk_ovr_on = 1'b0;
  logic       tmc = 1'b0;
  logic [3:0] unit_idle = 4'b0000;
  logic [3:0] unit_rstn;
  logic [3:0] unit_clk_en;
  logic       dla_ovr_sync;
  logic       glb_ovr_sync;
  logic       rst_done;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  nvdla_partition_rstclk_ctrl #(
    .NUM_UNITS  (4),
    .SYNC_DEPTH (3),
    .STAGGER    (4),
    .IDLE_HOLD  (16),
    .CNT_W      (8)
  ) dut (
    .nvdla_core_clk                (clk),
    .dla_reset_rstn                (dla_reset_rstn),
    .direct_reset_                 (direct_reset_),
    .test_mode                     (test_mode),
    .nvdla_clk_ovr_on              (nvdla_clk_ovr_on),
    .global_clk_ovr_on             (global_clk_ovr_on),
    .tmc2slcg_disable_clock_gating (tmc),
    .unit_idle                     (unit_idle),
    .unit_rstn                     (unit_rstn),
    .unit_clk_en                   (unit_clk_en),
    .dla_clk_ovr_on_sync           (dla_ovr_sync),
    .global_clk_ovr_on_sync        (glb_ovr_sync),
    .rst_done                      (rst_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] mk(logic [3:0] r, logic [3:0] e, logic d, logic dv, logic gv);
    return {5'b0, gv, dv, d, e, r};
  endfunction

  task automatic expect_at(int when, logic [15:0] mask, logic [15:0] val, string name);
    exp_t e;
    e.when = when;
    e.mask = mask;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  // Advance n rising edges and step just past the edge.
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected staggered release relative to the cycle raw reset rose.
  task automatic expect_sequence(int c, string tag);
    expect_at(c + 6,  MRstn | MDone, mk(4'b0000, 4'h0, 1'b0, 1'b0, 1'b0), {tag, "_pre_u0"});
    expect_at(c + 7,  MRstn | MDone, mk(4'b0001, 4'h0, 1'b0, 1'b0, 1'b0), {tag, "_u0"});
    expect_at(c + 10, MRstn | MDone, mk(4'b0001, 4'h0, 1'b0, 1'b0, 1'b0), {tag, "_pre_u1"});
    expect_at(c + 11, MRstn | MDone, mk(4'b0011, 4'h0, 1'b0, 1'b0, 1'b0), {tag, "_u1"});
    expect_at(c + 14, MRstn | MDone, mk(4'b0011, 4'h0, 1'b0, 1'b0, 1'b0), {tag, "_pre_u2"});
    expect_at(c + 15, MRstn | MDone, mk(4'b0111, 4'h0, 1'b0, 1'b0, 1'b0), {tag, "_u2"});
    expect_at(c + 18, MRstn | MDone, mk(4'b0111, 4'h0, 1'b0, 1'b0, 1'b0), {tag, "_pre_u3"});
    expect_at(c + 19, MRstn | MDone, mk(4'b1111, 4'h0, 1'b1, 1'b0, 1'b0), {tag, "_u3_done"});
    expect_at(c + 12, MEn, mk(4'h0, 4'hF, 1'b0, 1'b0, 1'b0), {tag, "_en_during_seq"});
  endtask

  // Monitor: compare every entry due this cycle, flag any that were skipped.
  initial begin
    logic [15:0] obs;
    exp_t        keep[$];
    forever begin
      @(negedge clk);
      obs = {5'b0, glb_ovr_sync, dla_ovr_sync, rst_done, unit_clk_en, unit_rstn};
      keep.delete();
      foreach (sb[i]) begin
        if (sb[i].when == cyc) begin
          checks++;
          if ((obs & sb[i].mask) !== (sb[i].val & sb[i].mask)) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, want %h (mask %h)", sb[i].name, cyc,
                     obs & sb[i].mask, sb[i].val & sb[i].mask, sb[i].mask);
          end
        end else if (sb[i].when < cyc) begin
          checks++;
          errors++;
          $display("FAIL %s: due at cycle %0d, not sampled (now %0d)", sb[i].name, sb[i].when,
                   cyc);
        end else begin
          keep.push_back(sb[i]);
        end
      end
      sb = keep;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    int c0, c1, c2, k, k2, g, d, t, m;

    // Reset state.
    tick(3);
    expect_at(cyc, 16'h07FF, mk(4'b0000, 4'hF, 1'b0, 1'b0, 1'b0), "reset_state");

    // Scenario 1: first release.
    dla_reset_rstn = 1'b1;
    c0 = cyc;
    expect_sequence(c0, "seq1");
    tick(22);

    // Secondary reset input also clears everything asynchronously.
    direct_reset_ = 1'b0;
    expect_at(cyc, MRstn | MDone | MEn, mk(4'b0000, 4'hF, 1'b0, 1'b0, 1'b0), "direct_reset");
    tick(2);
    direct_reset_ = 1'b1;

    // Scenario 2: reset asserted two cycles after unit 1 releases.
    c1 = cyc;
    expect_at(c1 + 11, MRstn, mk(4'b0011, 4'h0, 1'b0, 1'b0, 1'b0), "abort_u1");
    tick(13);
    dla_reset_rstn = 1'b0;
    expect_at(cyc, MRstn | MDone, mk(4'b0000, 4'h0, 1'b0, 1'b0, 1'b0), "abort_async_clear");
    tick(3);
    dla_reset_rstn = 1'b1;
    c2 = cyc;
    expect_sequence(c2, "seq2");
    tick(25);

    // Scenario 3: unit 2 idle held high, then busy again.
    unit_idle = 4'b0100;
    k = cyc;
    expect_at(k,      MEn, mk(4'h0, 4'hF, 1'b0, 1'b0, 1'b0), "idle2_start");
    expect_at(k + 15, MEn, mk(4'h0, 4'hF, 1'b0, 1'b0, 1'b0), "idle2_hold_last");
    expect_at(k + 16, MEn, mk(4'h0, 4'hB, 1'b0, 1'b0, 1'b0), "idle2_gated");
    expect_at(k + 19, MEn, mk(4'h0, 4'hB, 1'b0, 1'b0, 1'b0), "idle2_stays_gated");
    tick(20);
    unit_idle = 4'b0000;
    expect_at(cyc, MEn, mk(4'h0, 4'hF, 1'b0, 1'b0, 1'b0), "idle2_busy_zero_latency");

    // Scenario 4: short idle pulse on unit 1, then a full hold proves reload.
    tick(2);
    unit_idle = 4'b0010;
    k = cyc;
    expect_at(k + 5, MEn, mk(4'h0, 4'hF, 1'b0, 1'b0, 1'b0), "short_idle_mid");
    expect_at(k + 9, MEn, mk(4'h0, 4'hF, 1'b0, 1'b0, 1'b0), "short_idle_end");
    tick(10);
    unit_idle = 4'b0000;
    expect_at(cyc, MEn, mk(4'h0, 4'hF, 1'b0, 1'b0, 1'b0), "short_idle_drop");
    tick(2);
    unit_idle = 4'b0010;
    k2 = cyc;
    expect_at(k2 + 15, MEn, mk(4'h0, 4'hF, 1'b0, 1'b0, 1'b0), "reload_hold_last");
    expect_at(k2 + 16, MEn, mk(4'h0, 4'hD, 1'b0, 1'b0, 1'b0), "reload_gated");
    tick(18);
    unit_idle = 4'b0000;
    tick(2);

    // Scenario 5: all gated, global override pulse, fresh hold afterwards.
    unit_idle = 4'b1111;
    k = cyc;
    expect_at(k + 16, MEn, mk(4'h0, 4'h0, 1'b0, 1'b0, 1'b0), "all_gated");
    tick(20);
    global_clk_ovr_on = 1'b1;
    g = cyc;
    expect_at(g + 2,  MEn | MGovr, mk(4'h0, 4'h0, 1'b0, 1'b0, 1'b0), "govr_latency_pre");
    expect_at(g + 3,  MEn | MGovr, mk(4'h0, 4'hF, 1'b0, 1'b0, 1'b1), "govr_sync_on");
    expect_at(g + 4,  MEn | MGovr, mk(4'h0, 4'hF, 1'b0, 1'b0, 1'b0), "govr_sync_off");
    expect_at(g + 19, MEn, mk(4'h0, 4'hF, 1'b0, 1'b0, 1'b0), "govr_fresh_hold_last");
    expect_at(g + 20, MEn, mk(4'h0, 4'h0, 1'b0, 1'b0, 1'b0), "govr_regated");
    tick(1);
    global_clk_ovr_on = 1'b0;
    tick(21);

    // Partition override held for three cycles.
    nvdla_clk_ovr_on = 1'b1;
    d = cyc;
    expect_at(d + 2,  MEn | MDovr, mk(4'h0, 4'h0, 1'b0, 1'b0, 1'b0), "dovr_latency_pre");
    expect_at(d + 3,  MEn | MDovr, mk(4'h0, 4'hF, 1'b0, 1'b1, 1'b0), "dovr_sync_on");
    expect_at(d + 5,  MEn | MDovr, mk(4'h0, 4'hF, 1'b0, 1'b1, 1'b0), "dovr_sync_held");
    expect_at(d + 6,  MEn | MDovr, mk(4'h0, 4'hF, 1'b0, 1'b0, 1'b0), "dovr_sync_off");
    expect_at(d + 21, MEn, mk(4'h0, 4'hF, 1'b0, 1'b0, 1'b0), "dovr_fresh_hold_last");
    expect_at(d + 22, MEn, mk(4'h0, 4'h0, 1'b0, 1'b0, 1'b0), "dovr_regated");
    tick(3);
    nvdla_clk_ovr_on = 1'b0;
    tick(21);

    // Static clock-gating disable.
    tmc = 1'b1;
    t = cyc;
    expect_at(t,      MEn, mk(4'h0, 4'hF, 1'b0, 1'b0, 1'b0), "tmc_force_on");
    expect_at(t + 17, MEn, mk(4'h0, 4'hF, 1'b0, 1'b0, 1'b0), "tmc_fresh_hold_last");
    expect_at(t + 18, MEn, mk(4'h0, 4'h0, 1'b0, 1'b0, 1'b0), "tmc_regated");
    tick(2);
    tmc = 1'b0;
    tick(20);
    unit_idle = 4'b0000;
    expect_at(cyc, MEn, mk(4'h0, 4'hF, 1'b0, 1'b0, 1'b0), "all_busy_again");
    tick(2);

    // Scenario 6: scan mode.
    test_mode = 1'b1;
    unit_idle = 4'b1111;
    m = cyc;
    expect_at(m, MRstn | MEn | MDone, mk(4'b1111, 4'hF, 1'b1, 1'b0, 1'b0), "scan_entry");
    tick(2);
    dla_reset_rstn = 1'b0;
    expect_at(cyc, MRstn | MEn | MDone, mk(4'b0000, 4'hF, 1'b0, 1'b0, 1'b0), "scan_rst_low");
    tick(2);
    dla_reset_rstn = 1'b1;
    global_clk_ovr_on = 1'b1;
    expect_at(cyc, MRstn | MEn | MDone | MGovr, mk(4'b1111, 4'hF, 1'b1, 1'b0, 1'b1),
              "scan_rst_high_no_stagger");
    tick(2);
    global_clk_ovr_on = 1'b0;
    expect_at(cyc, MGovr | MEn, mk(4'h0, 4'hF, 1'b0, 1'b0, 1'b0), "scan_ovr_passthru_off");
    tick(1);

    for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      foreach (sb[i]) begin
        checks++;
        errors++;
        $display("FAIL %s: still pending at end, got unchecked, want checked", sb[i].name);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
